// File: rtl/mem_arbiter_pkg.sv
// Shared widths, fetch constants and FSM encoding for the memory arbiter.
package mem_arbiter_pkg;
   localparam int unsigned MemAddrBus = 32;
   localparam int unsigned MemDataBus = 32;
   localparam logic [2:0]  IfFetchLen = 3'd4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SERVE_IF  = 2'd1,
      SERVE_MEM = 2'd2,
      DRAIN     = 2'd3
   } arb_state_t;
endpackage

// File: rtl/mem_arb_pick.sv
// Arbitration between fetch and load/store, with starvation counter favouring IF.
module mem_arb_pick #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic arb_open,
   input  logic in_idle,
   input  logic if_elig,
   input  logic mem_elig,
   output logic grant_if,
   output logic grant_mem
);
   logic [2:0] starve_cnt;
   logic       starved;

   assign starved = (starve_cnt == 3'(STARVE_LIMIT));

   always_comb begin
      grant_if  = arb_open && if_elig && (!mem_elig || starved);
      grant_mem = arb_open && mem_elig && !grant_if;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (in_idle) begin
         if (grant_if || !if_elig)
            starve_cnt <= '0;
         else if (grant_mem && !starved)
            starve_cnt <= starve_cnt + 3'd1;
      end
   end
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: FSM plus registered downstream request and ready/data pulses.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [MemAddrBus-1:0] if_addr,
   input  logic                  if_flush,
   input  logic                  mem_req,
   input  logic                  mem_write,
   input  logic [MemAddrBus-1:0] mem_addr,
   input  logic [MemDataBus-1:0] mem_wdata,
   input  logic [2:0]            mem_len,
   input  logic                  mem_signed,
   output logic                  dn_valid,
   output logic                  dn_write,
   output logic [MemAddrBus-1:0] dn_addr,
   output logic [MemDataBus-1:0] dn_wdata,
   output logic [2:0]            dn_len,
   output logic                  dn_signed,
   input  logic                  dn_done,
   input  logic [MemDataBus-1:0] dn_rdata,
   output logic                  if_ready,
   output logic [MemDataBus-1:0] if_data,
   output logic                  mem_ready,
   output logic [MemDataBus-1:0] mem_rdata,
   output logic                  busy
);
   arb_state_t state, state_nx;
   logic armed, in_idle, arb_open, if_elig, mem_elig;
   logic grant_if, grant_mem, if_complete, mem_complete;

   assign in_idle  = (state == IDLE);
   assign if_elig  = if_req && !if_ready && !if_flush;
   assign mem_elig = mem_req && !mem_ready;
   // No grant while a ready pulse is out, so a held request is re-arbitrated fairly next cycle.
   assign arb_open = in_idle && armed && !if_ready && !mem_ready;
   assign dn_valid = !in_idle;
   assign busy     = !in_idle;

   mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
      .clock    (clock),
      .reset    (reset),
      .arb_open (arb_open),
      .in_idle  (in_idle),
      .if_elig  (if_elig),
      .mem_elig (mem_elig),
      .grant_if (grant_if),
      .grant_mem(grant_mem)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         armed <= 1'b0;
      end else begin
         state <= state_nx;
         armed <= 1'b1;
      end
   end

   always_comb begin
      state_nx     = state;
      if_complete  = 1'b0;
      mem_complete = 1'b0;
      unique case (state)
         IDLE: begin
            if (grant_mem)     state_nx = SERVE_MEM;
            else if (grant_if) state_nx = SERVE_IF;
         end
         SERVE_IF: begin
            if (dn_done) begin
               state_nx    = IDLE;
               if_complete = !if_flush;
            end else if (if_flush) begin
               state_nx = DRAIN;
            end
         end
         SERVE_MEM: begin
            if (dn_done) begin
               state_nx     = IDLE;
               mem_complete = 1'b1;
            end
         end
         DRAIN: begin
            if (dn_done) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dn_write  <= 1'b0;
         dn_addr   <= '0;
         dn_wdata  <= '0;
         dn_len    <= '0;
         dn_signed <= 1'b0;
         if_ready  <= 1'b0;
         if_data   <= '0;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
      end else begin
         if_ready  <= if_complete;
         mem_ready <= mem_complete;
         if (if_complete)  if_data   <= dn_rdata;
         if (mem_complete) mem_rdata <= dn_write ? '0 : dn_rdata;
         if (grant_mem) begin
            dn_write  <= mem_write;
            dn_addr   <= mem_addr;
            dn_wdata  <= mem_wdata;
            dn_len    <= mem_len;
            dn_signed <= mem_signed;
         end else if (grant_if) begin
            dn_write  <= 1'b0;
            dn_addr   <= if_addr;
            dn_wdata  <= '0;
            dn_len    <= IfFetchLen;
            dn_signed <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;
   logic        clock, reset;
   logic        if_req, if_flush;
   logic [31:0] if_addr;
   logic        mem_req, mem_write, mem_signed;
   logic [31:0] mem_addr, mem_wdata;
   logic [2:0]  mem_len;
   logic        dn_valid, dn_write, dn_signed, dn_done;
   logic [31:0] dn_addr, dn_wdata, dn_rdata;
   logic [2:0]  dn_len;
   logic        if_ready, mem_ready, busy;
   logic [31:0] if_data, mem_rdata;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_len(mem_len), .mem_signed(mem_signed),
      .dn_valid(dn_valid), .dn_write(dn_write), .dn_addr(dn_addr),
      .dn_wdata(dn_wdata), .dn_len(dn_len), .dn_signed(dn_signed),
      .dn_done(dn_done), .dn_rdata(dn_rdata),
      .if_ready(if_ready), .if_data(if_data),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
      mem_req = 1'b0; mem_write = 1'b0; mem_signed = 1'b0;
      mem_addr = '0; mem_wdata = '0; mem_len = '0;
      dn_done = 1'b0; dn_rdata = '0;
      tick(); tick();
      check("rst_dn_valid", 32'(dn_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", {30'd0, if_ready, mem_ready}, 32'd0);
      check("rst_dn_addr", dn_addr, 32'd0);

      // fetch 0x100, done three cycles after dn_valid
      reset = 1'b0; if_req = 1'b1; if_addr = 32'h100;
      tick();
      check("no_grant_first_edge", 32'(dn_valid), 32'd0);
      tick();
      check("if_grant_valid", 32'(dn_valid), 32'd1);
      check("if_grant_addr", dn_addr, 32'h100);
      check("if_grant_len", 32'(dn_len), 32'd4);
      check("if_grant_write", 32'(dn_write), 32'd0);
      tick(); tick();
      check("if_hold_addr", dn_addr, 32'h100);
      check("if_hold_valid", 32'(dn_valid), 32'd1);
      tick();
      dn_done = 1'b1; dn_rdata = 32'hDEADBEEF;
      tick();
      check("if_ready_pulse", 32'(if_ready), 32'd1);
      check("if_data", if_data, 32'hDEADBEEF);
      check("if_done_valid_drop", 32'(dn_valid), 32'd0);
      dn_done = 1'b0; if_req = 1'b0;
      tick();
      check("if_ready_one_cycle", 32'(if_ready), 32'd0);
      check("idle_after_if", 32'(busy), 32'd0);

      // simultaneous IF and MEM load; mem_req held through the ready cycle
      if_req = 1'b1; if_addr = 32'h200;
      mem_req = 1'b1; mem_write = 1'b0; mem_addr = 32'h20; mem_len = 3'd2; mem_signed = 1'b1;
      tick();
      check("mem_first_addr", dn_addr, 32'h20);
      check("mem_first_len", 32'(dn_len), 32'd2);
      check("mem_first_signed", 32'(dn_signed), 32'd1);
      dn_done = 1'b1; dn_rdata = 32'h0000BEEF;
      tick();
      check("mem_ready_pulse", 32'(mem_ready), 32'd1);
      check("mem_rdata", mem_rdata, 32'h0000BEEF);
      check("no_if_ready_with_mem", 32'(if_ready), 32'd0);
      dn_done = 1'b0;
      tick();
      check("no_dup_mem_grant", 32'(dn_valid), 32'd0);
      mem_req = 1'b0;
      tick();
      check("if_after_mem_valid", 32'(dn_valid), 32'd1);
      check("if_after_mem_addr", dn_addr, 32'h200);
      check("if_after_mem_signed", 32'(dn_signed), 32'd0);
      dn_done = 1'b1; dn_rdata = 32'h11111111;
      tick();
      check("if2_data", if_data, 32'h11111111);
      dn_done = 1'b0; if_req = 1'b0;
      tick();

      // starvation: MEM held continuously with odd length, IF waits
      if_req = 1'b1; if_addr = 32'h300;
      mem_req = 1'b1; mem_addr = 32'h80; mem_len = 3'd7; mem_signed = 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
         tick();
         check("starve_mem_addr", dn_addr, 32'h80);
         check("starve_mem_len", 32'(dn_len), 32'd7);
         dn_done = 1'b1; dn_rdata = 32'(k) + 32'hA0;
         tick();
         check("starve_mem_rdata", mem_rdata, 32'(k) + 32'hA0);
         dn_done = 1'b0;
         tick();
      end
      tick();
      check("starve_if_addr", dn_addr, 32'h300);
      check("starve_if_len", 32'(dn_len), 32'd4);
      mem_req = 1'b0; dn_done = 1'b1; dn_rdata = 32'h33;
      tick();
      check("starve_if_ready", 32'(if_ready), 32'd1);
      dn_done = 1'b0; if_req = 1'b0;
      tick();

      // flush two cycles into SERVE_IF, MEM waits until drain completes
      if_req = 1'b1; if_addr = 32'h400;
      tick();
      check("flush_grant_addr", dn_addr, 32'h400);
      tick(); tick();
      if_flush = 1'b1;
      tick();
      if_flush = 1'b0; if_req = 1'b0;
      mem_req = 1'b1; mem_write = 1'b0; mem_addr = 32'h90; mem_len = 3'd1;
      check("drain_valid", 32'(dn_valid), 32'd1);
      tick();
      check("drain_holds_addr", dn_addr, 32'h400);
      dn_done = 1'b1; dn_rdata = 32'h12345678;
      tick();
      check("drain_no_ready", {30'd0, if_ready, mem_ready}, 32'd0);
      check("drain_end_valid", 32'(dn_valid), 32'd0);
      dn_done = 1'b0;
      tick();
      check("post_drain_mem_addr", dn_addr, 32'h90);
      dn_done = 1'b1; dn_rdata = 32'h5A;
      tick();
      mem_req = 1'b0; dn_done = 1'b0;
      tick();

      // flush together with dn_done
      if_req = 1'b1; if_addr = 32'h500;
      tick();
      if_flush = 1'b1; dn_done = 1'b1; dn_rdata = 32'h55;
      tick();
      check("flush_done_no_ready", 32'(if_ready), 32'd0);
      check("flush_done_idle", 32'(busy), 32'd0);
      if_flush = 1'b0; dn_done = 1'b0; if_req = 1'b0;
      tick();

      // store with flush during SERVE_MEM (ignored), rdata must read zero
      mem_req = 1'b1; mem_write = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hA5A5A5A5; mem_len = 3'd4;
      tick();
      check("store_write", 32'(dn_write), 32'd1);
      check("store_wdata", dn_wdata, 32'hA5A5A5A5);
      if_flush = 1'b1;
      tick();
      dn_done = 1'b1; dn_rdata = 32'hFFFFFFFF;
      tick();
      check("store_ready_despite_flush", 32'(mem_ready), 32'd1);
      check("store_rdata_zero", mem_rdata, 32'd0);
      if_flush = 1'b0; dn_done = 1'b0; mem_req = 1'b0;
      tick(); tick();

      // reset mid SERVE_MEM, then stray dn_done
      mem_req = 1'b1;
      tick();
      check("store2_valid", 32'(dn_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_valid", 32'(dn_valid), 32'd0);
      check("async_rst_addr", dn_addr, 32'd0);
      check("async_rst_wdata", dn_wdata, 32'd0);
      tick();
      reset = 1'b0; mem_req = 1'b0; dn_done = 1'b1; dn_rdata = 32'h77;
      tick();
      check("stray_done_no_ready", 32'(mem_ready), 32'd0);
      tick();
      check("stray_done_idle", 32'(busy), 32'd0);
      check("stray_done_rdata", mem_rdata, 32'd0);
      dn_done = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
